// File: rtl/sap1_controller.sv
// SAP-1 control sequencer.
// A six-state one-hot ring (T1..T6) plus a sticky halted bit forms the whole
// state. The control word is decoded combinationally from the registered ring
// position and the live opcode, so each strobe is valid for the full state and
// is captured by the consuming register at the closing clock edge.
module sap1_controller #(
  parameter int OPCODE_W = 4,
  parameter int T_STATES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [5:0]          tstate,
  output logic                cp,
  output logic                ep,
  output logic                lm_n,
  output logic                ce_n,
  output logic                li_n,
  output logic                ei_n,
  output logic                la_n,
  output logic                ea,
  output logic                su,
  output logic                eu,
  output logic                lb_n,
  output logic                lo_n,
  output logic                hlt
);

  // The ring length is baked into the decode below; refuse any other size.
  if (T_STATES != 6) begin : g_bad_ring_length
    $error("sap1_controller: T_STATES must be 6");
  end

  // Instruction opcodes as seen in the IR upper nibble.
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

  // One-hot ring positions; the encoding is the externally visible tstate.
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  // Control word held in asserted (active-high) form; pin polarity is applied
  // only at the output assignments.
  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctl_t;

  ring_t state;
  ring_t state_next;
  logic  halted;
  logic  halted_next;
  ctl_t  ctl;

  // State register: reset restarts the ring at T1 and clears the halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= T1;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  // Next state: advance the ring unless halted; HLT freezes the ring at T4.
  always_comb begin
    state_next  = state;
    halted_next = halted;
    if (!halted) begin
      if (state == T4 && opcode == OP_HLT) begin
        halted_next = 1'b1;
      end else begin
        case (state)
          T1:      state_next = T2;
          T2:      state_next = T3;
          T3:      state_next = T4;
          T4:      state_next = T5;
          T5:      state_next = T6;
          T6:      state_next = T1;
          default: state_next = T1;
        endcase
      end
    end
  end

  // Control decode: fetch ignores the opcode, execute depends on it; reset
  // and halt mask every strobe.
  always_comb begin
    ctl = '0;
    if (!rst && !halted) begin
      case (state)
        T1: begin
          ctl.ep = 1'b1;
          ctl.lm = 1'b1;
        end
        T2: begin
          ctl.cp = 1'b1;
        end
        T3: begin
          ctl.ce = 1'b1;
          ctl.li = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ctl.ei = 1'b1;
              ctl.lm = 1'b1;
            end
            OP_OUT: begin
              ctl.ea = 1'b1;
              ctl.lo = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ctl.ce = 1'b1;
              ctl.la = 1'b1;
            end
            OP_ADD: begin
              ctl.ce = 1'b1;
              ctl.lb = 1'b1;
            end
            OP_SUB: begin
              ctl.ce = 1'b1;
              ctl.lb = 1'b1;
              ctl.su = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              ctl.eu = 1'b1;
              ctl.la = 1'b1;
            end
            OP_SUB: begin
              ctl.eu = 1'b1;
              ctl.la = 1'b1;
              ctl.su = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign tstate = state;
  assign cp     = ctl.cp;
  assign ep     = ctl.ep;
  assign lm_n   = ~ctl.lm;
  assign ce_n   = ~ctl.ce;
  assign li_n   = ~ctl.li;
  assign ei_n   = ~ctl.ei;
  assign la_n   = ~ctl.la;
  assign ea     = ctl.ea;
  assign su     = ctl.su;
  assign eu     = ctl.eu;
  assign lb_n   = ~ctl.lb;
  assign lo_n   = ~ctl.lo;
  assign hlt    = halted & ~rst;

endmodule

// File: tb/tb_sap1_controller.sv
// Testbench for the SAP-1 control sequencer.
// Directed vector table, a hand-written halt sequence and a random opcode
// stream checked against a microprogram-table reference model.
module tb_sap1_controller;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic [5:0] tstate;
  logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt;

  int tests_run = 0;
  int tests_failed = 0;

  // Asserted-form bit positions of the 13-bit control word.
  localparam int CP = 12, EP = 11, LM = 10, CE = 9, LI = 8, EI = 7, LA = 6;
  localparam int EA = 5, SU = 4, EU = 3, LB = 2, LO = 1, HL = 0;

  localparam logic [12:0] F1 = (13'd1 << EP) | (13'd1 << LM);
  localparam logic [12:0] F2 = (13'd1 << CP);
  localparam logic [12:0] F3 = (13'd1 << CE) | (13'd1 << LI);

  // Microprogram table: expected asserted strobes per opcode and ring step.
  logic [12:0] rom [16][6];

  // Reference model state: ring step 0..5 and halt flag.
  int   m_step;
  logic m_halt;

  typedef struct {
    string       name;
    logic        r;
    logic [3:0]  op;
    logic [5:0]  t;
    logic [12:0] w;
  } vec_t;

  vec_t vecs[$];

  sap1_controller #(.OPCODE_W(4), .T_STATES(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .tstate(tstate),
    .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
    .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n), .lo_n(lo_n),
    .hlt(hlt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] word_of(input logic [12:0] bits);
    return bits;
  endfunction

  function automatic logic [12:0] bit_of(input int pos);
    return 13'd1 << pos;
  endfunction

  task automatic build_rom();
    for (int o = 0; o < 16; o++) begin
      rom[o][0] = F1;
      rom[o][1] = F2;
      rom[o][2] = F3;
      for (int s = 3; s < 6; s++) rom[o][s] = '0;
    end
    rom[0][3]  = bit_of(EI) | bit_of(LM);
    rom[0][4]  = bit_of(CE) | bit_of(LA);
    rom[1][3]  = bit_of(EI) | bit_of(LM);
    rom[1][4]  = bit_of(CE) | bit_of(LB);
    rom[1][5]  = bit_of(EU) | bit_of(LA);
    rom[2][3]  = bit_of(EI) | bit_of(LM);
    rom[2][4]  = bit_of(CE) | bit_of(LB) | bit_of(SU);
    rom[2][5]  = bit_of(EU) | bit_of(LA) | bit_of(SU);
    rom[14][3] = bit_of(EA) | bit_of(LO);
  endtask

  function automatic logic [12:0] model_word(input logic r, input logic [3:0] op);
    if (r) return '0;
    if (m_halt) return bit_of(HL);
    return rom[op][m_step];
  endfunction

  function automatic logic [5:0] model_tstate();
    return 6'(1 << m_step);
  endfunction

  task automatic add(input string n, input logic r, input logic [3:0] op,
                     input logic [5:0] t, input logic [12:0] w);
    vec_t v;
    v.name = n; v.r = r; v.op = op; v.t = t; v.w = w;
    vecs.push_back(v);
  endtask

  task automatic add_instr(input string n, input logic [3:0] op,
                           input logic [12:0] w4, input logic [12:0] w5,
                           input logic [12:0] w6);
    add({n, "_t1"}, 1'b0, op, 6'b000001, F1);
    add({n, "_t2"}, 1'b0, op, 6'b000010, F2);
    add({n, "_t3"}, 1'b0, op, 6'b000100, F3);
    add({n, "_t4"}, 1'b0, op, 6'b001000, w4);
    add({n, "_t5"}, 1'b0, op, 6'b010000, w5);
    add({n, "_t6"}, 1'b0, op, 6'b100000, w6);
  endtask

  // Drive inputs just after a rising edge and wait to the falling edge.
  task automatic applyStimulus(input logic r, input logic [3:0] op);
    rst = r;
    opcode = op;
    @(negedge clk);
  endtask

  // Close the cycle: rising edge, update the model with the applied inputs.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_step = 0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_step == 3 && opcode == 4'hF) m_halt = 1'b1;
      else m_step = (m_step + 1) % 6;
    end
    #1;
  endtask

  // Compare DUT outputs to expectations, plus the per-cycle invariants.
  task automatic checkOutput(input string n, input logic [5:0] exp_t,
                             input logic [12:0] exp_w);
    logic [12:0] got_w;
    int drivers;
    got_w = {cp, ep, ~lm_n, ~ce_n, ~li_n, ~ei_n, ~la_n, ea, su, eu,
             ~lb_n, ~lo_n, hlt};
    tests_run++;
    if (tstate !== exp_t || got_w !== exp_w) begin
      tests_failed++;
      $display("[TB] FAIL %s: got tstate=%b word=%b, expected tstate=%b word=%b",
               n, tstate, got_w, exp_t, exp_w);
    end
    drivers = int'(ep) + int'(~ce_n) + int'(~ei_n) + int'(ea) + int'(eu);
    tests_run++;
    if (drivers > 1 || !$onehot(tstate)) begin
      tests_failed++;
      $display("[TB] FAIL %s_invariant: drivers=%0d tstate=%b, expected drivers<=1 and one-hot",
               n, drivers, tstate);
    end
  endtask

  initial begin
    logic        r;
    logic [3:0]  op;
    build_rom();
    m_step = 0;
    m_halt = 1'b0;

    // Directed table, starting from a held reset.
    add("reset_a", 1'b1, 4'h0, 6'b000001, '0);
    add("reset_b", 1'b1, 4'h0, 6'b000001, '0);
    add_instr("add", 4'b0001, bit_of(EI) | bit_of(LM), bit_of(CE) | bit_of(LB),
              bit_of(EU) | bit_of(LA));
    add_instr("sub", 4'b0010, bit_of(EI) | bit_of(LM),
              bit_of(CE) | bit_of(LB) | bit_of(SU),
              bit_of(EU) | bit_of(LA) | bit_of(SU));
    add_instr("lda", 4'b0000, bit_of(EI) | bit_of(LM), bit_of(CE) | bit_of(LA), '0);
    add_instr("out", 4'b1110, bit_of(EA) | bit_of(LO), '0, '0);
    add_instr("nop1", 4'b0101, '0, '0, '0);
    add_instr("nop2", 4'b0101, '0, '0, '0);
    add("fetch_op_f", 1'b0, 4'hF, 6'b000001, F1);
    add("fetch_op_0", 1'b0, 4'h0, 6'b000010, F2);
    add("fetch_op_e", 1'b0, 4'hE, 6'b000100, F3);
    add("chg_add_t4", 1'b0, 4'h1, 6'b001000, bit_of(EI) | bit_of(LM));
    add("chg_add_t5", 1'b0, 4'h1, 6'b010000, bit_of(CE) | bit_of(LB));
    add("chg_add_t6", 1'b0, 4'h1, 6'b100000, bit_of(EU) | bit_of(LA));
    add("abort_t1", 1'b0, 4'h0, 6'b000001, F1);
    add("abort_t2", 1'b0, 4'h0, 6'b000010, F2);
    add("abort_t3", 1'b0, 4'h0, 6'b000100, F3);
    add("abort_t4", 1'b0, 4'h0, 6'b001000, bit_of(EI) | bit_of(LM));
    add("abort_rst", 1'b1, 4'h0, 6'b010000, '0);
    add_instr("after_abort", 4'b0000, bit_of(EI) | bit_of(LM),
              bit_of(CE) | bit_of(LA), '0);

    rst = 1'b1;
    opcode = 4'h0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].op);
      checkOutput(vecs[i].name, vecs[i].t, word_of(vecs[i].w));
      advance();
    end

    // Halt: freeze at T4 for 20 cycles, then a reset pulse releases it.
    applyStimulus(1'b0, 4'hF); checkOutput("hlt_t1", 6'b000001, F1); advance();
    applyStimulus(1'b0, 4'hF); checkOutput("hlt_t2", 6'b000010, F2); advance();
    applyStimulus(1'b0, 4'hF); checkOutput("hlt_t3", 6'b000100, F3); advance();
    applyStimulus(1'b0, 4'hF); checkOutput("hlt_t4", 6'b001000, '0); advance();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 4'(i));
      checkOutput("hlt_hold", 6'b001000, bit_of(HL));
      advance();
    end
    applyStimulus(1'b1, 4'hF); checkOutput("hlt_rst", 6'b001000, '0); advance();
    applyStimulus(1'b0, 4'h5); checkOutput("hlt_release", 6'b000001, F1); advance();

    // Random opcode stream; opcode only changes outside T4..T6.
    op = 4'h5;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 29) == 0);
      if ((m_step < 3 || m_halt) && $urandom_range(0, 1) == 1) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF) op = 4'($urandom_range(0, 15));
      end
      applyStimulus(r, op);
      checkOutput("random", model_tstate(), model_word(r, op));
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
